// File: rtl/instruction_fetch.sv
// instruction_fetch: byte-PC instruction fetch with valid/ready output, redirects and an ack watchdog.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned redirect targets (oMISALIGN + STALL) instead of forcing alignment.
module instruction_fetch #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         TIMEOUT  = 16
) (
  input  logic        iCLK,
  input  logic        iRST,
  output logic        oMEM_REQ,
  output logic [7:0]  oMEM_ADDR,
  input  logic        iMEM_ACK,
  input  logic [31:0] iMEM_RDATA,
  output logic [31:0] oIR,
  output logic [7:0]  oPC,
  output logic        oVALID,
  input  logic        iREADY,
  input  logic        iBR_TAKEN,
  input  logic [7:0]  iBR_TARGET,
  output logic        oMISALIGN,
  output logic        oFAULT
);
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif
  localparam logic [7:0] TO = 8'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, REQ, HOLD, STALL} state_t;
  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d, opc_q, opc_d, cnt_q, cnt_d, tgt;
  logic [31:0] ir_q, ir_d;
  logic        valid_q, valid_d, fault_q, fault_d, mis_q, mis_d, redir, bad_tgt;
  // Without the check the low target bits are dropped, so a bad target can never trap.
  assign tgt     = ALIGN_CHK ? iBR_TARGET : {iBR_TARGET[7:2], 2'b00};
  assign bad_tgt = ALIGN_CHK && (iBR_TARGET[1:0] != 2'b00);
  assign redir   = iBR_TAKEN && (state_q != IDLE);
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      opc_q   <= RESET_PC;
      ir_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      opc_q   <= opc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      mis_q   <= mis_d;
    end
  end
  // Redirect outranks ack and ready; a same-cycle ack is simply dropped.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    opc_d   = opc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    fault_d = fault_q;
    mis_d   = mis_q;
    if (redir) begin
      pc_d    = tgt;
      valid_d = 1'b0;
      cnt_d   = '0;
      mis_d   = mis_q | bad_tgt;
      state_d = bad_tgt ? STALL : REQ;
    end else if (state_q == IDLE) begin
      state_d = REQ;
    end else if (state_q == REQ && iMEM_ACK) begin
      ir_d    = iMEM_RDATA;
      opc_d   = pc_q;
      valid_d = 1'b1;
      cnt_d   = '0;
      state_d = HOLD;
    end else if (state_q == REQ) begin
      cnt_d   = cnt_q + 8'd1;
      state_d = (cnt_d == TO) ? STALL : REQ;
      fault_d = fault_q | (cnt_d == TO);
    end else if (state_q == HOLD && iREADY) begin
      valid_d = 1'b0;
      pc_d    = pc_q + 8'd4;
      state_d = REQ;
    end
  end
  always_comb begin
    oMEM_REQ  = state_q == REQ;
    oMEM_ADDR = pc_q;
    oIR       = ir_q;
    oPC       = opc_q;
    oVALID    = valid_q;
    oFAULT    = fault_q;
    oMISALIGN = mis_q;
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: vector table, corner sequences and randomized run against a flag-based fetch model.
module tb_instruction_fetch;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int TO = 16;
  logic clk = 1'b0, rst, req, ack, valid, ready, br, mis, fault;
  logic [7:0] addr, pc, tgt;
  logic [31:0] rdata, ir;
  int n_cmp = 0, n_err = 0;

  instruction_fetch #(.RESET_PC(8'h00), .TIMEOUT(TO)) dut (
    .iCLK(clk), .iRST(rst), .oMEM_REQ(req), .oMEM_ADDR(addr), .iMEM_ACK(ack), .iMEM_RDATA(rdata),
    .oIR(ir), .oPC(pc), .oVALID(valid), .iREADY(ready), .iBR_TAKEN(br), .iBR_TARGET(tgt),
    .oMISALIGN(mis), .oFAULT(fault));

  always #5 clk = ~clk;

  bit m_idle, m_req, m_valid, m_fault, m_mis;
  logic [7:0] m_pc, m_opc;
  logic [31:0] m_ir;
  int m_wait;

  // Reference: the fetch unit is idle, waiting on memory, holding a word, or parked.
  task automatic model_step();
    logic [7:0] t;
    if (rst) begin
      m_idle = 1; m_req = 0; m_valid = 0; m_fault = 0; m_mis = 0;
      m_pc = 8'h00; m_opc = 8'h00; m_ir = 0; m_wait = 0;
    end else if (m_idle) begin
      m_idle = 0; m_req = 1;
    end else if (br) begin
      t = CHK ? tgt : (tgt & 8'hFC);
      m_pc = t; m_valid = 0; m_wait = 0;
      m_req = !(CHK && t[1:0] != 0);
      if (!m_req) m_mis = 1;
    end else if (m_req && ack) begin
      m_ir = rdata; m_opc = m_pc; m_valid = 1; m_req = 0; m_wait = 0;
    end else if (m_req) begin
      m_wait++;
      if (m_wait == TO) begin m_req = 0; m_fault = 1; end
    end else if (m_valid && ready) begin
      m_valid = 0; m_pc = m_pc + 8'd4; m_req = 1;
    end
  endtask

  task automatic drive(int r, int a, logic [31:0] d, int y, int b, int t);
    rst = r != 0; ack = a != 0; rdata = d; ready = y != 0; br = b != 0; tgt = 8'(t);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    int r, a; logic [31:0] d; int y, b, t;
    logic [49:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(int r, int a, logic [31:0] d, int y, int b, int t,
                             int q, int ad, int vl, int p, logic [31:0] w);
    vec_t x;
    x.r = r; x.a = a; x.d = d; x.y = y; x.b = b; x.t = t;
    x.exp = {1'(q), 8'(ad), 1'(vl), 8'(p), w};
    return x;
  endfunction

  initial begin
    // rst ack data rdy br tgt | req addr valid pc ir
    tbl.push_back(v(1, 0, 0, 0, 0, 0,      0, 'h00, 0, 'h00, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,      1, 'h00, 0, 'h00, 0));
    tbl.push_back(v(0, 1, 32'hA0A00001, 1, 0, 0, 0, 'h00, 1, 'h00, 32'hA0A00001));
    tbl.push_back(v(0, 0, 0, 1, 0, 0,      1, 'h04, 0, 'h00, 32'hA0A00001));
    tbl.push_back(v(0, 1, 32'hA1A10002, 1, 0, 0, 0, 'h04, 1, 'h04, 32'hA1A10002));
    tbl.push_back(v(0, 0, 0, 1, 0, 0,      1, 'h08, 0, 'h04, 32'hA1A10002));
    tbl.push_back(v(0, 1, 32'hA2A20003, 0, 0, 0, 0, 'h08, 1, 'h08, 32'hA2A20003));
    for (int i = 0; i < 5; i++)
      tbl.push_back(v(0, 1, 32'hEEEEEEEE, 0, 0, 0, 0, 'h08, 1, 'h08, 32'hA2A20003));
    tbl.push_back(v(0, 0, 0, 1, 0, 0,      1, 'h0C, 0, 'h08, 32'hA2A20003));
    tbl.push_back(v(0, 1, 32'hA3A30004, 0, 1, 'h40, 1, 'h40, 0, 'h08, 32'hA2A20003));
    tbl.push_back(v(0, 1, 32'hA4A40005, 0, 0, 0, 0, 'h40, 1, 'h40, 32'hA4A40005));
    tbl.push_back(v(0, 0, 0, 1, 1, 'h20,   1, 'h20, 0, 'h40, 32'hA4A40005));
    tbl.push_back(v(0, 1, 32'hA5A50006, 0, 0, 0, 0, 'h20, 1, 'h20, 32'hA5A50006));
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].y, tbl[i].b, tbl[i].t);
      chk($sformatf("vec%0d", i), {req, addr, valid, pc, ir}, tbl[i].exp);
      chk($sformatf("vec%0d_flags", i), {fault, mis}, 0);
    end

    // PC wrap from 0xFC
    drive(1, 0, 0, 0, 0, 0); drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 'hFC);
    chk("wrap_req", {req, addr}, {1'b1, 8'hFC});
    drive(0, 1, 32'hD0D0D0D0, 0, 0, 0);
    chk("wrap_hold", {valid, pc, ir}, {1'b1, 8'hFC, 32'hD0D0D0D0});
    drive(0, 0, 0, 1, 0, 0);
    chk("wrap_next", {req, addr, fault, mis}, {1'b1, 8'h00, 2'b00});

    // Watchdog
    drive(1, 0, 0, 0, 0, 0); drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) drive(0, 0, 0, 1, 0, 0);
    chk("wd_before", {req, fault}, 2'b10);
    drive(0, 0, 0, 1, 0, 0);
    chk("wd_fault", {req, fault, valid}, 3'b010);
    for (int i = 0; i < 3; i++) drive(0, 1, 32'h12345678, 1, 0, 0);
    chk("wd_stuck", {req, fault, valid, ir}, {3'b010, 32'h0});
    drive(0, 0, 0, 0, 1, 'h10);
    chk("wd_redir", {req, addr, fault}, {1'b1, 8'h10, 1'b1});
    drive(0, 1, 32'h55AA55AA, 0, 0, 0);
    chk("wd_fetch", {valid, pc, ir, fault}, {1'b1, 8'h10, 32'h55AA55AA, 1'b1});
    drive(1, 0, 0, 0, 0, 0);
    chk("wd_clear", {fault, req, valid}, 3'b000);

    // Reset mid-request, late ack, redirect while idle
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 1, 32'hBEEFBEEF, 0, 0, 0);
    chk("rst_abandon", {req, valid, ir}, {2'b00, 32'h0});
    drive(0, 1, 32'hBEEFBEEF, 0, 1, 'h80);
    chk("idle_ignore", {req, addr, valid, ir}, {1'b1, 8'h00, 1'b0, 32'h0});

    // Misaligned redirect
    drive(0, 0, 0, 0, 1, 'h42);
    if (CHK) begin
      chk("mis_trap", {req, addr, mis, valid}, {1'b0, 8'h42, 2'b10});
      drive(0, 1, 32'h1, 1, 0, 0);
      chk("mis_stall", {req, valid, mis}, 3'b001);
      drive(0, 0, 0, 0, 1, 'h44);
      chk("mis_leave", {req, addr, mis}, {1'b1, 8'h44, 1'b1});
    end else begin
      chk("mis_align", {req, addr, mis, valid}, {1'b1, 8'h40, 2'b00});
      drive(0, 1, 32'h77, 0, 0, 0);
      chk("mis_fetch", {valid, pc, ir}, {1'b1, 8'h40, 32'h77});
    end

    // Randomized run with varying memory responsiveness
    drive(1, 0, 0, 0, 0, 0);
    for (int s = 0; s < 15; s++) begin
      int pa;
      pa = (s % 3 == 0) ? 90 : (s % 3 == 1) ? 50 : 4;
      for (int i = 0; i < 200; i++) begin
        drive(($urandom_range(199) == 0) ? 1 : 0,
              ($urandom_range(99) < pa) ? 1 : 0, $urandom(),
              ($urandom_range(99) < 60) ? 1 : 0,
              ($urandom_range(99) < 5) ? 1 : 0, $urandom_range(255));
        chk("rand", {req, addr, valid, pc, ir, fault, mis},
            {m_req, m_pc, m_valid, m_opc, m_ir, m_fault, m_mis});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Front-end stage that fetches 32-bit instructions from instruction memory using an 8-bit byte PC.
- Presents each instruction word and its PC to the decode/execute units (R/I/S/B/U/J) through a valid/ready handshake.
- Accepts branch/jump redirects from execute.
- Includes a memory-response watchdog.

Parameters:
- RESET_PC, 8'h00, PC loaded on reset.
- TIMEOUT, 16, maximum cycles to wait for iMEM_ACK before flagging a fault (range 2..255).

Ports:
- iCLK  input  1  clock; all logic on the rising edge.
- iRST  input  1  synchronous, active-high reset.
- oMEM_REQ  output  1  instruction memory read request.
- oMEM_ADDR  output  8  byte address of the request; equals the current PC.
- iMEM_ACK  input  1  memory returns data this cycle.
- iMEM_RDATA  input  32  instruction word; valid when iMEM_ACK=1.
- oIR  output  32  fetched instruction to the execute units.
- oPC  output  8  PC of oIR.
- oVALID  output  1  oIR/oPC hold a valid instruction.
- iREADY  input  1  downstream consumes the instruction when oVALID and iREADY are both 1.
- iBR_TAKEN  input  1  redirect request from execute.
- iBR_TARGET  input  8  redirect byte address.
- oMISALIGN  output  1  sticky flag: redirect target had bits[1:0] != 0.
- oFAULT  output  1  sticky flag: memory timeout.

Behaviour:
- Reset (iRST=1 at a rising edge): state=IDLE, PC=RESET_PC, oIR=32'h0, oPC=RESET_PC, oVALID=0, oMEM_REQ=0, oMISALIGN=0, oFAULT=0, watchdog counter=0. Reset mid-request abandons the request; a late iMEM_ACK is ignored.
- States:
  - IDLE: one cycle after reset release; goes to REQ.
  - REQ: oMEM_REQ=1, oMEM_ADDR=PC; counter increments each cycle without ack. On iMEM_ACK: oIR<=iMEM_RDATA, oPC<=PC, oVALID<=1, counter<=0, go to HOLD.
  - HOLD: oMEM_REQ=0, outputs stable. On iREADY: oVALID<=0, PC<=PC+4, go to REQ.
  - STALL: entered from REQ when counter reaches TIMEOUT. oFAULT<=1 (sticky until reset), oMEM_REQ=0, oVALID=0. Only reset or redirect leaves STALL.
- Latency: reset released at edge N -> oMEM_REQ=1 from edge N+1. Ack in the same cycle as the request -> oVALID=1 one cycle later. Back-to-back throughput is one instruction per 2 cycles with zero-wait memory.
- PC arithmetic is 8-bit modulo: 8'hFC+4 wraps to 8'h00, no flag.
- Redirect (iBR_TAKEN=1) takes priority over iMEM_ACK and iREADY in every state except IDLE:
  - Effect: PC<=iBR_TARGET, oVALID<=0, counter<=0, next state REQ.
  - A same-cycle ack is discarded.
  - A redirect in HOLD with iREADY=1 counts as consumed; no PC+4.
  - A redirect in IDLE is ignored.
- iMEM_ACK outside REQ is ignored.
- oMEM_ADDR is always driven with PC; only oMEM_REQ qualifies it.

Optional Feature:
- FETCH_ALIGN_CHECK_EN defined: a redirect with iBR_TARGET[1:0]!=0 sets oMISALIGN (sticky) and enters STALL instead of REQ. PC is still loaded with the raw target.
- Not defined: iBR_TARGET[1:0] is forced to 2'b00 on load, and oMISALIGN is tied to 0.

Test Plan:
- Reset, memory acks on every request, iREADY=1 -> oMEM_ADDR sequence 0x00,0x04,0x08; oVALID pulses every 2nd cycle; oPC matches; oIR matches memory words.
- iREADY held 0 for 5 cycles in HOLD -> oIR/oPC/oVALID stable, no new oMEM_REQ; iREADY=1 -> next request at PC+4.
- iBR_TAKEN=1, iBR_TARGET=8'h40, in the same cycle as iMEM_ACK -> data discarded, oVALID stays 0, next request address 0x40, next oPC=0x40.
- Start at PC 8'hFC, accept -> next oMEM_ADDR=8'h00, no flags.
- Withhold iMEM_ACK for TIMEOUT=16 cycles -> oFAULT=1, oMEM_REQ=0; redirect to 0x10 -> REQ at 0x10 with oFAULT still 1; iRST clears it.
- Redirect to 8'h42: with FETCH_ALIGN_CHECK_EN -> oMISALIGN=1, STALL entered; without it -> request at 0x40, oMISALIGN=0.
